// File: rtl/kmap_scan_pkg.sv
// Shared types and scan ordering for the 4-input truth-table scanner.
// Define KMAP_SCAN_GRAY_ORDER_EN to walk input codes in Gray order.
package kmap_scan_pkg;
  localparam int N_IN  = 4;
  localparam int TBL_W = 2**N_IN;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } kmap_state_e;

  // Maps scan position to the input code driven on x_out.
  function automatic logic [N_IN-1:0] scan_code(input logic [N_IN-1:0] idx);
`ifdef KMAP_SCAN_GRAY_ORDER_EN
    return idx ^ (idx >> 1);
`else
    return idx;
`endif
  endfunction
endpackage

// File: rtl/kmap_settle_timer.sv
// Hold timer: strobes on the last cycle of every SETTLE_CYCLES+1 cycle hold,
// reloading itself so consecutive holds run back to back while enabled.
module kmap_settle_timer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CW            = 4
) (
  input  logic clk,
  input  logic areset,
  input  logic load,
  input  logic en,
  output logic strobe
);
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge areset) begin
    if (areset)           cnt <= '0;
    else if (load)        cnt <= RELOAD;
    else if (en)          cnt <= (cnt == '0) ? RELOAD : cnt - 1'b1;
  end

  assign strobe = en & (cnt == '0);
endmodule

// File: rtl/kmap_scan_ctrl.sv
// Built-in self-check sequencer: drives all input codes of a 4-input function,
// samples f_in after a settle hold, and grades the table against a golden mask.
// Scan order is binary by default, Gray when KMAP_SCAN_GRAY_ORDER_EN is defined.
module kmap_scan_ctrl
  import kmap_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             start,
  input  logic [TBL_W-1:0] golden,
  output logic [N_IN-1:0]  x_out,
  input  logic             f_in,
  output logic             busy,
  output logic             done,
  output logic [TBL_W-1:0] table_out,
  output logic [N_IN:0]    mismatch_cnt,
  output logic [N_IN-1:0]  first_mismatch,
  output logic             pass
);
  kmap_state_e      state;
  logic [N_IN-1:0]  idx;
  logic [TBL_W-1:0] golden_q;
  logic             accept, sample, miss, last;
  logic [N_IN:0]    cnt_nxt;

  assign accept  = (state == IDLE) & start;
  assign miss    = sample & (f_in != golden_q[x_out]);
  assign last    = (idx == N_IN'(TBL_W - 1));
  assign cnt_nxt = mismatch_cnt + {{N_IN{1'b0}}, miss};

  kmap_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES), .CW(4)) u_timer (
    .clk    (clk),
    .areset (areset),
    .load   (accept),
    .en     (state == SCAN),
    .strobe (sample)
  );

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state          <= IDLE;
      idx            <= '0;
      golden_q       <= '0;
      x_out          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      table_out      <= '0;
      mismatch_cnt   <= '0;
      first_mismatch <= '0;
      pass           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          golden_q       <= golden;
          table_out      <= '0;
          mismatch_cnt   <= '0;
          first_mismatch <= '0;
          pass           <= 1'b0;
          idx            <= '0;
          x_out          <= scan_code('0);
          busy           <= 1'b1;
          state          <= SCAN;
        end
        SCAN: if (sample) begin
          table_out[x_out] <= f_in;
          mismatch_cnt     <= cnt_nxt;
          // a zero running count means no earlier mismatch in this scan
          if (miss && (mismatch_cnt == '0)) first_mismatch <= x_out;
          if (last) begin
            done  <= 1'b1;
            pass  <= (cnt_nxt == '0);
            state <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            x_out <= scan_code(idx + 1'b1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_kmap_scan_ctrl.sv
// Randomized bench for kmap_scan_ctrl with a per-cycle behavioural model.
module tb_kmap_scan_ctrl;
  import kmap_scan_pkg::*;

  localparam int S      = 1;
  localparam int T_DONE = 16 * (S + 1);

  logic        clk = 1'b0, areset = 1'b1, start = 1'b0;
  logic [15:0] golden = '0, tbl = '0;
  logic        f_in, busy, done, pass;
  logic [3:0]  x_out, first_mismatch;
  logic [15:0] table_out;
  logic [4:0]  mismatch_cnt;

  int n_chk = 0, n_fail = 0;

  assign f_in = tbl[x_out];
  always #5 clk = ~clk;

  kmap_scan_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .areset(areset), .start(start), .golden(golden),
    .x_out(x_out), .f_in(f_in), .busy(busy), .done(done),
    .table_out(table_out), .mismatch_cnt(mismatch_cnt),
    .first_mismatch(first_mismatch), .pass(pass)
  );

  int order[16];
  initial
    for (int i = 0; i < 16; i++)
`ifdef KMAP_SCAN_GRAY_ORDER_EN
      order[i] = i ^ (i >> 1);
`else
      order[i] = i;
`endif

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: position in the scan is just cycles since acceptance; results are the
  // graded prefix of the scan order completed so far.
  bit          m_busy = 0;
  int          m_t = 0;
  logic [15:0] m_gold = '0, m_tbl = '0;
  logic [15:0] e_tbl = '0;
  int          e_cnt = 0, e_fm = 0, e_x = 0;
  bit          e_busy = 0, e_done = 0, e_pass = 0;

  always @(posedge clk or posedge areset) begin
    if (areset) begin
      m_busy = 0; m_t = 0;
      e_tbl = '0; e_cnt = 0; e_fm = 0; e_x = 0;
      e_busy = 0; e_done = 0; e_pass = 0;
    end else begin
      if (m_busy) begin
        if (m_t == T_DONE) m_busy = 0;
        else m_t++;
      end else if (start) begin
        m_busy = 1; m_t = 0; m_gold = golden; m_tbl = tbl;
      end
      if (m_busy) begin
        int k;
        k = (m_t >= T_DONE) ? 16 : m_t / (S + 1);
        e_tbl = '0; e_cnt = 0; e_fm = 0;
        for (int j = 0; j < k; j++) begin
          e_tbl[order[j]] = m_tbl[order[j]];
          if (m_tbl[order[j]] != m_gold[order[j]]) begin
            if (e_cnt == 0) e_fm = order[j];
            e_cnt++;
          end
        end
        e_x    = order[(k < 16) ? k : 15];
        e_busy = 1;
        e_done = (m_t == T_DONE);
        e_pass = (m_t == T_DONE) && (e_cnt == 0);
      end else begin
        e_busy = 0;
        e_done = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", busy, e_busy);
    check("done", done, e_done);
    check("x_out", x_out, e_x);
    check("table_out", table_out, e_tbl);
    check("mismatch_cnt", mismatch_cnt, e_cnt);
    check("first_mismatch", first_mismatch, e_fm);
    check("pass", pass, e_pass);
  end

  // Returns with time at the negedge where done is high (or budget exhausted).
  task automatic run_scan(input logic [15:0] g, input logic [15:0] t, input bit disturb,
                          output int lat);
    @(negedge clk); #2;
    golden = g; tbl = t; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (lat < 200) begin
      @(negedge clk);
      if (done === 1'b1) break;
      @(posedge clk); #1;
      lat++;
      if (disturb && lat == 6) begin start = 1'b1; golden = ~g; end
      if (disturb && lat == 7) start = 1'b0;
    end
  endtask

  task automatic expect_result(input string nm, input logic [15:0] t, input int cnt,
                               input int fm, input bit p);
    check({nm, ".table"}, table_out, t);
    check({nm, ".cnt"}, mismatch_cnt, cnt);
    check({nm, ".first"}, first_mismatch, fm);
    check({nm, ".pass"}, pass, p);
  endtask

  initial begin
    int lat, pulses;
    logic [31:0] r;
    repeat (3) @(negedge clk);
    #2 areset = 1'b0;
    repeat (2) @(negedge clk);

    run_scan(16'hD073, 16'hD073, 0, lat);
    check("latency", lat, T_DONE + 1);
    expect_result("exact", 16'hD073, 0, 0, 1);

    run_scan(16'hD072, 16'hD073, 0, lat);
    expect_result("one_bit", 16'hD073, 1, 0, 0);

    run_scan(16'h2F8C, 16'hD073, 0, lat);
    expect_result("inverse", 16'hD073, 16, 0, 0);

    run_scan(16'hD073, 16'hD073 ^ 16'h0020, 0, lat);
    expect_result("fault5", 16'hD053, 1, 5, 0);

    // reset ten cycles into a scan, then a clean rescan
    @(negedge clk); #2;
    golden = 16'hD073; tbl = 16'hD073; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 areset = 1'b1;
    @(negedge clk);
    check("rst.busy", busy, 0);
    check("rst.x_out", x_out, 0);
    @(negedge clk); #2 areset = 1'b0;
    run_scan(16'hD073, 16'hD073, 0, lat);
    check("rst.latency", lat, T_DONE + 1);
    expect_result("after_rst", 16'hD073, 0, 0, 1);

    run_scan(16'hD073, 16'hD073, 1, lat);
    expect_result("disturb", 16'hD073, 0, 0, 1);
    @(negedge clk); #2 golden = 16'h0000;

    // held start: back-to-back scans with one idle cycle between
    @(negedge clk); #2;
    golden = 16'hD072; tbl = 16'hD073; start = 1'b1;
    pulses = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("held.pulses", pulses, 2);
    #2 start = 1'b0;
    for (int i = 0; i < 100 && busy === 1'b1; i++) @(negedge clk);
    check("held.idle", busy, 0);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #2;
      r = $urandom;
      if (!m_busy && r[3:0] == 4'd0) tbl = 16'($urandom);
      golden = (r[7:4] == 4'd0) ? ~tbl : tbl ^ 16'($urandom & $urandom & $urandom);
      start  = ($urandom_range(0, 3) == 0);
      areset = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk); #2 areset = 1'b0; start = 1'b0;
    repeat (T_DONE + 4) @(negedge clk);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
